// File: rtl/prog_down_counter_if.sv
// Switch/button inputs and count/status outputs of the loadable countdown timer.
// The bench or board top drives the master side; prog_down_counter takes the slave side.
interface prog_down_counter_if;
  logic [3:0] sw_in;
  logic       btn_load;
  logic       btn_start;
  logic [3:0] cout;
  logic       done;
  logic       running;
  logic       tick;

  modport master (
    output sw_in, btn_load, btn_start,
    input  cout, done, running, tick
  );

  modport slave (
    input  sw_in, btn_load, btn_start,
    output cout, done, running, tick
  );
endinterface

// File: rtl/prog_down_counter.sv
// Loadable 4-bit countdown timer with debounced load and start/pause buttons.
// Optional feature macro: PROG_DOWN_COUNTER_AUTO_RELOAD_EN (reload from init instead of stopping at zero).
module prog_down_counter #(
  parameter int unsigned DIVISOR         = 32'd125000000,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1250000
) (
  input  logic                 clock,
  input  logic                 rst,
  prog_down_counter_if.slave   bus
);

  localparam logic [31:0] DIV_LAST = 32'(DIVISOR - 1);
  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  logic [1:0]  btn_raw;
  logic [1:0]  sync_p0, sync_p1;
  logic [1:0]  db_lvl, db_lvl_d;
  logic [23:0] db_cnt [2];
  logic        load_ev, start_ev;

  assign btn_raw = {bus.btn_start, bus.btn_load};

  // Synchronizer -> debouncer (count restarts whenever the input matches the accepted level again)
  always_ff @(posedge clock) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign load_ev  = db_lvl[0] & ~db_lvl_d[0];
  assign start_ev = db_lvl[1] & ~db_lvl_d[1];

  state_t      state_q, state_n;
  logic [3:0]  cout_q, cout_n;
  logic [31:0] div_q, div_n;
  logic        done_q, running_q, tick_q;
  logic        div_hit, reload;

`ifdef PROG_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [3:0]  init_q;

  always_ff @(posedge clock) begin
    if (rst)          init_q <= '0;
    else if (load_ev) init_q <= bus.sw_in;
  end
`endif

  always_ff @(posedge clock) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Next state; load wins over start when both arrive together
  always_comb begin
    state_n = state_q;
    cout_n  = cout_q;
    div_n   = div_q;
    reload  = 1'b0;
    div_hit = (state_q == S_RUN) && (div_q == DIV_LAST);
    case (state_q)
      S_IDLE: begin
        if (load_ev) begin
          cout_n = bus.sw_in;
        end else if (start_ev) begin
          if (cout_q != 4'd0) begin
            state_n = S_RUN;
            div_n   = '0;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (div_hit) begin
          div_n = '0;
          if (cout_q == 4'd1) begin
`ifdef PROG_DOWN_COUNTER_AUTO_RELOAD_EN
            if (init_q != 4'd0) begin
              cout_n = init_q;
              reload = 1'b1;
            end else begin
              cout_n  = 4'd0;
              state_n = S_DONE;
            end
`else
            cout_n  = 4'd0;
            state_n = S_DONE;
`endif
          end else begin
            cout_n = sat_dec(cout_q);
          end
        end else begin
          div_n = div_q + 32'd1;
        end
        if (start_ev && (state_n == S_RUN)) state_n = S_PAUSE;
      end
      S_PAUSE: begin
        if (load_ev) begin
          cout_n  = bus.sw_in;
          state_n = S_IDLE;
        end else if (start_ev) begin
          state_n = S_RUN;
        end
      end
      S_DONE: begin
        if (load_ev) begin
          cout_n  = bus.sw_in;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs track the state register; tick is predicted so it leads the decrement
  always_ff @(posedge clock) begin
    if (rst) begin
      cout_q    <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cout_q    <= cout_n;
      div_q     <= div_n;
      done_q    <= (state_n == S_DONE) || reload;
      running_q <= (state_n == S_RUN);
      tick_q    <= (state_n == S_RUN) && (div_n == DIV_LAST);
    end
  end

  assign bus.cout    = cout_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_q;

endmodule
